// File: rtl/pipe_mem_wb_nport_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : pipe_mem_wb_nport_if                                 |
// | Bundles the MEM->WB lane bus, stall/flush control, the retired   |
// | counter and, when WB_FWD_EN is defined, the forwarding port.     |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
interface pipe_mem_wb_nport_if #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int NPORT  = 2,
  parameter int CNT_W  = 32
);
  logic                    stall;
  logic                    flush;
  logic [NPORT-1:0]        mem_valid;
  logic [NPORT-1:0]        mem_regwrite;
  logic [NPORT*RD_W-1:0]   mem_rd;
  logic [NPORT*DATA_W-1:0] mem_data;
  logic [NPORT-1:0]        wb_valid;
  logic [NPORT-1:0]        wb_regwrite;
  logic [NPORT*RD_W-1:0]   wb_rd;
  logic [NPORT*DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]        retired_cnt;
`ifdef WB_FWD_EN
  logic [RD_W-1:0]         fwd_rs;
  logic                    fwd_hit;
  logic [DATA_W-1:0]       fwd_data;
`endif

`ifdef WB_FWD_EN
  modport master (
    output stall, flush, mem_valid, mem_regwrite, mem_rd, mem_data, fwd_rs,
    input  wb_valid, wb_regwrite, wb_rd, wb_data, retired_cnt, fwd_hit, fwd_data
  );
  modport slave (
    input  stall, flush, mem_valid, mem_regwrite, mem_rd, mem_data, fwd_rs,
    output wb_valid, wb_regwrite, wb_rd, wb_data, retired_cnt, fwd_hit, fwd_data
  );
`else
  modport master (
    output stall, flush, mem_valid, mem_regwrite, mem_rd, mem_data,
    input  wb_valid, wb_regwrite, wb_rd, wb_data, retired_cnt
  );
  modport slave (
    input  stall, flush, mem_valid, mem_regwrite, mem_rd, mem_data,
    output wb_valid, wb_regwrite, wb_rd, wb_data, retired_cnt
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_mem_wb_nport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pipe_mem_wb_nport                                     |
// | NPORT-lane MEM->WB pipeline register, STAGES deep, with valid    |
// | tracking, stall/flush, XZR write suppression and a retired-      |
// | instruction counter. Optional macro WB_FWD_EN adds a read-port   |
// | style forwarding lookup over all stored entries.                 |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pipe_mem_wb_nport #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int NPORT  = 2,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  wire logic             clk,
  input  wire logic             resetl,
  pipe_mem_wb_nport_if.slave    bus
);

  localparam logic [RD_W-1:0] c_XZR = {RD_W{1'b1}};

  // Stage k of every field; stage STAGES-1 drives the wb_* outputs.
  logic [STAGES-1:0][NPORT-1:0]        r_valid;
  logic [STAGES-1:0][NPORT-1:0]        r_we;
  logic [STAGES-1:0][NPORT*RD_W-1:0]   r_rd;
  logic [STAGES-1:0][NPORT*DATA_W-1:0] r_data;
  logic [CNT_W-1:0]                    r_cnt;

  logic [NPORT-1:0]        w_we;
  logic [NPORT*RD_W-1:0]   w_rd;
  logic [NPORT*DATA_W-1:0] w_data;
  logic [CNT_W-1:0]        w_pop;

  // Capture qualification: XZR writes are dropped, data of non-writing lanes is zeroed.
  always_comb begin
    w_we   = '0;
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_we[i] = bus.mem_valid[i] & bus.mem_regwrite[i] &
                (bus.mem_rd[i*RD_W +: RD_W] != c_XZR);
      if (bus.mem_valid[i])
        w_rd[i*RD_W +: RD_W] = bus.mem_rd[i*RD_W +: RD_W];
      if (w_we[i])
        w_data[i*DATA_W +: DATA_W] = bus.mem_data[i*DATA_W +: DATA_W];
    end
  end

  // Number of valid lanes leaving the last stage on an advance.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NPORT; i++)
      w_pop = w_pop + CNT_W'(r_valid[STAGES-1][i]);
  end

  // Delay line and retired counter; priority reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      r_valid <= '0;
      r_we    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_we    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (!bus.stall) begin
      r_valid[0] <= bus.mem_valid;
      r_we[0]    <= w_we;
      r_rd[0]    <= w_rd;
      r_data[0]  <= w_data;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_data[k]  <= r_data[k-1];
      end
      r_cnt <= r_cnt + w_pop;
    end
  end

  assign bus.wb_valid    = r_valid[STAGES-1];
  assign bus.wb_regwrite = r_we[STAGES-1];
  assign bus.wb_rd       = r_rd[STAGES-1];
  assign bus.wb_data     = r_data[STAGES-1];
  assign bus.retired_cnt = r_cnt;

`ifdef WB_FWD_EN
  logic              w_hit;
  logic [DATA_W-1:0] w_fdata;

  // Forward lookup: scan oldest-to-youngest so the last match (youngest) wins.
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    if (bus.fwd_rs != c_XZR) begin
      for (int k = STAGES-1; k >= 0; k--) begin
        for (int i = 0; i < NPORT; i++) begin
          if (r_we[k][i] && (r_rd[k][i*RD_W +: RD_W] == bus.fwd_rs)) begin
            w_hit   = 1'b1;
            w_fdata = r_data[k][i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign bus.fwd_hit  = w_hit;
  assign bus.fwd_data = w_fdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_wb_nport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_pipe_mem_wb_nport                                  |
// | Self-checking bench: directed scenarios plus random traffic,     |
// | compared against a queue-based reference model.                  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_pipe_mem_wb_nport;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int NPORT  = 2;
  localparam int STAGES = 2;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [NPORT-1:0]        v;
    logic [NPORT-1:0]        we;
    logic [NPORT*RD_W-1:0]   rd;
    logic [NPORT*DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic resetl;

  pipe_mem_wb_nport_if #(.DATA_W(DATA_W), .RD_W(RD_W), .NPORT(NPORT), .CNT_W(CNT_W)) bus ();

  pipe_mem_wb_nport #(
    .DATA_W(DATA_W), .RD_W(RD_W), .NPORT(NPORT), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue front = youngest (stage 0), back = oldest (output).
  ent_t             mq[$];
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic ent_t bubble();
    ent_t e;
    e = '0;
    return e;
  endfunction

  // Stored form of an incoming instruction group, from the writeback rules.
  function automatic ent_t capture(input logic [NPORT-1:0] v, input logic [NPORT-1:0] w,
                                   input logic [NPORT*RD_W-1:0] rd,
                                   input logic [NPORT*DATA_W-1:0] d);
    ent_t e;
    e = '0;
    e.v = v;
    for (int i = 0; i < NPORT; i++) begin
      e.we[i] = v[i] && w[i] && (rd[i*RD_W +: RD_W] != 5'd31);
      if (v[i])     e.rd[i*RD_W +: RD_W]       = rd[i*RD_W +: RD_W];
      if (e.we[i])  e.data[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
    end
    return e;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int k = 0; k < STAGES; k++) mq.push_front(bubble());
  endtask

  task automatic check_outputs();
    ent_t o;
    o = mq[$];
    check("wb_valid",    128'(bus.wb_valid),    128'(o.v));
    check("wb_regwrite", 128'(bus.wb_regwrite), 128'(o.we));
    check("wb_rd",       128'(bus.wb_rd),       128'(o.rd));
    check("wb_data",     128'(bus.wb_data),     128'(o.data));
    check("retired_cnt", 128'(bus.retired_cnt), 128'(m_cnt));
`ifdef WB_FWD_EN
    begin
      logic             ehit;
      logic [DATA_W-1:0] edat;
      ehit = 1'b0;
      edat = '0;
      if (bus.fwd_rs != 5'd31) begin
        for (int k = 0; k < STAGES && !ehit; k++) begin
          for (int i = NPORT-1; i >= 0 && !ehit; i--) begin
            if (mq[k].we[i] && mq[k].rd[i*RD_W +: RD_W] == bus.fwd_rs) begin
              ehit = 1'b1;
              edat = mq[k].data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      check("fwd_hit",  128'(bus.fwd_hit),  128'(ehit));
      check("fwd_data", 128'(bus.fwd_data), 128'(edat));
    end
`endif
  endtask

  // Apply one cycle of stimulus, advance the model, compare after the edge.
  task automatic cycle(input logic st, input logic fl, input logic [NPORT-1:0] v,
                       input logic [NPORT-1:0] w, input logic [NPORT*RD_W-1:0] rd,
                       input logic [NPORT*DATA_W-1:0] d);
    ent_t dep;
    bus.stall        = st;
    bus.flush        = fl;
    bus.mem_valid    = v;
    bus.mem_regwrite = w;
    bus.mem_rd       = rd;
    bus.mem_data     = d;
    @(posedge clk);
    #1;
    if (!resetl) begin
      model_clear();
      m_cnt = '0;
    end else if (fl) begin
      model_clear();
    end else if (!st) begin
      dep   = mq.pop_back();
      m_cnt = m_cnt + CNT_W'($countones(dep.v));
      mq.push_front(capture(v, w, rd, d));
    end
    check_outputs();
  endtask

  function automatic logic [RD_W-1:0] rand_rd();
    if ($urandom_range(0, 5) == 0) return 5'd31;
    return RD_W'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle(input logic st, input logic fl);
    logic [NPORT*RD_W-1:0] rd;
    for (int i = 0; i < NPORT; i++) rd[i*RD_W +: RD_W] = rand_rd();
`ifdef WB_FWD_EN
    bus.fwd_rs = rand_rd();
`endif
    cycle(st, fl, NPORT'($urandom), NPORT'($urandom), rd,
          {$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  logic [CNT_W-1:0] cnt_save;

  initial begin
    m_cnt = '0;
    model_clear();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
`ifdef WB_FWD_EN
    bus.fwd_rs = '0;
`endif

    // Reset two cycles with random inputs.
    resetl = 1'b0;
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b1, 1'b0);
    resetl = 1'b1;

    // Dual-lane pair appears exactly STAGES cycles later.
    cnt_save = bus.retired_cnt;
    cycle(1'b0, 1'b0, 2'b11, 2'b11, {5'd4, 5'd3}, {64'hBB, 64'hAA});
    idle();
    check("pair_rd",   128'(bus.wb_rd),   128'({5'd4, 5'd3}));
    check("pair_data", 128'(bus.wb_data), 128'({64'hBB, 64'hAA}));
    idle();
    check("pair_cnt",  128'(bus.retired_cnt), 128'(cnt_save + 32'd2));

    // XZR write suppressed but still retired.
    cycle(1'b0, 1'b0, 2'b01, 2'b01, {5'd0, 5'd31}, {64'h0, 64'h1234});
    idle();
    check("xzr_valid", 128'(bus.wb_valid),    128'(2'b01));
    check("xzr_we",    128'(bus.wb_regwrite), 128'(2'b00));
    check("xzr_data",  128'(bus.wb_data),     128'(0));
    cnt_save = bus.retired_cnt;
    idle();
    check("xzr_cnt",   128'(bus.retired_cnt), 128'(cnt_save + 32'd1));

    // Stall three cycles mid-stream.
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b0);

    // Flush with stall while two valid entries are in flight.
    cycle(1'b0, 1'b0, 2'b11, 2'b11, {5'd1, 5'd2}, {64'h5, 64'h6});
    cycle(1'b0, 1'b0, 2'b11, 2'b11, {5'd7, 5'd6}, {64'h7, 64'h8});
    cnt_save = bus.retired_cnt;
    cycle(1'b1, 1'b1, 2'b11, 2'b11, {5'd1, 5'd1}, {64'h9, 64'h9});
    check("flush_valid", 128'(bus.wb_valid),    128'(0));
    check("flush_data",  128'(bus.wb_data),     128'(0));
    check("flush_cnt",   128'(bus.retired_cnt), 128'(cnt_save));

`ifdef WB_FWD_EN
    // Youngest matching stage wins; XZR lookup never hits.
    cycle(1'b0, 1'b0, 2'b01, 2'b01, {5'd0, 5'd5}, {64'h0, 64'h22});
    cycle(1'b0, 1'b0, 2'b01, 2'b01, {5'd0, 5'd5}, {64'h0, 64'h11});
    bus.fwd_rs = 5'd5;
    #1;
    check("fwd5_hit",  128'(bus.fwd_hit),  128'(1));
    check("fwd5_data", 128'(bus.fwd_data), 128'(64'h11));
    bus.fwd_rs = 5'd31;
    #1;
    check("fwd31_hit", 128'(bus.fwd_hit),  128'(0));
`endif

    // Random traffic with occasional stall and flush.
    for (int n = 0; n < 300; n++)
      rand_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);

    // Mid-run reset.
    resetl = 1'b0;
    rand_cycle(1'b0, 1'b0);
    resetl = 1'b1;
    for (int n = 0; n < 50; n++)
      rand_cycle($urandom_range(0, 4) == 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
